// File: rtl/image2dram_pkg.sv
// Shared constants and state encodings for the Image2DRAM pixel-to-beat writer.
package image2dram_pkg;

  localparam int unsigned BEAT_BYTES     = 64;
  localparam int unsigned WORDS_PER_BEAT = 16;

  typedef enum logic [1:0] {
    F_IDLE,
    F_RUN,
    F_FLUSH,
    F_DONE
  } frame_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ISSUE,
    W_ACK,
    W_WAIT
  } write_state_e;

endpackage

// File: rtl/pixel_beat_packer.sv
// Packs pixels into beats through a pack register and a hold register;
// hold is presented as a valid/ready source to the DRAM writer.
module pixel_beat_packer #(
  parameter int unsigned PIXEL_WIDTH    = 32,
  parameter int unsigned WORDS_PER_BEAT = 16,
  parameter int unsigned DATA_WIDTH     = PIXEL_WIDTH * WORDS_PER_BEAT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   run,
  input  logic [PIXEL_WIDTH-1:0] tdata,
  input  logic                   tvalid,
  input  logic                   tlast,
  output logic                   tready,
  output logic                   beat_valid,
  output logic [DATA_WIDTH-1:0]  beat_data,
  input  logic                   beat_release,
  output logic                   empty
);

  localparam int unsigned       LANE_W    = (WORDS_PER_BEAT > 1) ? $clog2(WORDS_PER_BEAT) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(WORDS_PER_BEAT - 1);

  logic [LANE_W-1:0]     lane_idx;
  logic [DATA_WIDTH-1:0] pack_data;
  logic                  pack_full;
  logic [DATA_WIDTH-1:0] beat_next;
  logic                  accept;
  logic                  complete;
  logic                  hold_free;
  logic                  move;

  assign tready    = run & ~(pack_full & beat_valid);
  assign accept    = tvalid & tready;
  assign complete  = accept & (tlast | (lane_idx == LAST_LANE));
  assign hold_free = ~beat_valid | beat_release;
  assign move      = pack_full & hold_free;
  assign empty     = ~pack_full & ~beat_valid;

  // Lane 0 starts from zero so lanes left unfilled by an early tlast read as 0.
  always_comb begin
    beat_next = (lane_idx == '0) ? '0 : pack_data;
    beat_next[int'(lane_idx)*PIXEL_WIDTH +: PIXEL_WIDTH] = tdata;
  end

  // A completing pixel bypasses pack straight into hold when hold is free,
  // which gives the one-cycle lane-16-to-request latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_idx   <= '0;
      pack_data  <= '0;
      pack_full  <= 1'b0;
      beat_data  <= '0;
      beat_valid <= 1'b0;
    end else begin
      if (beat_release) beat_valid <= 1'b0;
      if (clear) begin
        lane_idx  <= '0;
        pack_data <= '0;
        pack_full <= 1'b0;
      end
      if (move) begin
        beat_data  <= pack_data;
        beat_valid <= 1'b1;
        pack_full  <= 1'b0;
      end
      if (accept) begin
        if (complete) begin
          lane_idx <= '0;
          if (hold_free && !move) begin
            beat_data  <= beat_next;
            beat_valid <= 1'b1;
          end else begin
            pack_data <= beat_next;
            pack_full <= 1'b1;
          end
        end else begin
          pack_data <= beat_next;
          lane_idx  <= lane_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/image_dram_writer.sv
// AXI4-Stream pixel intake packed into 64-byte beats, each written as a
// single-beat request on the DRAM controller's write interface.
module image_dram_writer #(
  parameter int unsigned AXI_ADDR_WIDTH  = 39,
  parameter int unsigned DRAM_DATA_WIDTH = 512,
  parameter int unsigned PIXEL_WIDTH     = 32,
  parameter int unsigned WORDS_PER_BEAT  = DRAM_DATA_WIDTH / PIXEL_WIDTH,
  parameter int unsigned BEAT_CNT_WIDTH  = 24
) (
  input  logic                       m_axi_aclk,
  input  logic                       m_axi_areset,
  input  logic                       start,
  input  logic [AXI_ADDR_WIDTH-1:0]  frame_base_addr,
  input  logic [PIXEL_WIDTH-1:0]     s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [AXI_ADDR_WIDTH-1:0]  dram_write_addr,
  output logic [7:0]                 dram_write_len,
  output logic                       dram_write_en,
  output logic [DRAM_DATA_WIDTH-1:0] dram_write_data,
  input  logic                       dram_write_busy,
  output logic                       frame_busy,
  output logic                       frame_done,
  output logic [BEAT_CNT_WIDTH-1:0]  beat_count
);

  import image2dram_pkg::*;

  localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_STEP   = AXI_ADDR_WIDTH'(BEAT_BYTES);
  localparam logic [AXI_ADDR_WIDTH-1:0] OFFSET_MASK = AXI_ADDR_WIDTH'(BEAT_BYTES - 1);

  frame_state_e fstate, fstate_next;
  write_state_e wstate, wstate_next;

  logic [AXI_ADDR_WIDTH-1:0]  addr;
  logic                       frame_start;
  logic                       last_accept;
  logic                       beat_valid;
  logic [DRAM_DATA_WIDTH-1:0] beat_data;
  logic                       beat_release;
  logic                       pack_empty;

  assign frame_start     = (fstate == F_IDLE) & start;
  assign last_accept     = s_axis_tvalid & s_axis_tready & s_axis_tlast;
  assign frame_busy      = (fstate == F_RUN) | (fstate == F_FLUSH);
  assign frame_done      = (fstate == F_DONE);
  assign dram_write_addr = addr;
  assign dram_write_data = beat_data;
  assign dram_write_len  = 8'd0;

  pixel_beat_packer #(
    .PIXEL_WIDTH   (PIXEL_WIDTH),
    .WORDS_PER_BEAT(WORDS_PER_BEAT),
    .DATA_WIDTH    (DRAM_DATA_WIDTH)
  ) u_packer (
    .clk         (m_axi_aclk),
    .rst         (m_axi_areset),
    .clear       (frame_start),
    .run         (fstate == F_RUN),
    .tdata       (s_axis_tdata),
    .tvalid      (s_axis_tvalid),
    .tlast       (s_axis_tlast),
    .tready      (s_axis_tready),
    .beat_valid  (beat_valid),
    .beat_data   (beat_data),
    .beat_release(beat_release),
    .empty       (pack_empty)
  );

  always_comb begin
    fstate_next = fstate;
    case (fstate)
      F_IDLE:  if (start) fstate_next = F_RUN;
      F_RUN:   if (last_accept) fstate_next = F_FLUSH;
      F_FLUSH: if (pack_empty && wstate == W_IDLE) fstate_next = F_DONE;
      F_DONE:  fstate_next = F_IDLE;
      default: fstate_next = F_IDLE;
    endcase
  end

  // en is decoded from W_IDLE against the live busy input so a request is
  // never raised while the controller reports busy.
  always_comb begin
    wstate_next   = wstate;
    dram_write_en = 1'b0;
    beat_release  = 1'b0;
    case (wstate)
      W_IDLE: begin
        if (beat_valid && !dram_write_busy) begin
          dram_write_en = 1'b1;
          wstate_next   = W_ISSUE;
        end
      end
      W_ISSUE: wstate_next = W_ACK;
      W_ACK:   wstate_next = W_WAIT;
      W_WAIT: begin
        if (!dram_write_busy) begin
          beat_release = 1'b1;
          wstate_next  = W_IDLE;
        end
      end
      default: wstate_next = W_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      fstate     <= F_IDLE;
      wstate     <= W_IDLE;
      addr       <= '0;
      beat_count <= '0;
    end else begin
      fstate <= fstate_next;
      wstate <= wstate_next;
      if (frame_start) begin
        addr       <= frame_base_addr & ~OFFSET_MASK;
        beat_count <= '0;
      end else if (beat_release) begin
        addr       <= addr + BEAT_STEP;
        beat_count <= beat_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_image_dram_writer.sv
// Directed bench for image_dram_writer with a simple busy-generating controller model.
module tb_image_dram_writer;

  localparam int AW = 39;
  localparam int DW = 512;
  localparam int PW = 32;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [PW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [AW-1:0] dram_write_addr;
  logic [7:0]    dram_write_len;
  logic          dram_write_en;
  logic [DW-1:0] dram_write_data;
  logic          dram_write_busy;
  logic          frame_busy;
  logic          frame_done;
  logic [CW-1:0] beat_count;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned done_cnt = 0;
  int unsigned busy_cnt = 0;
  logic        force_busy = 1'b0;
  logic [AW-1:0] wq_addr[$];
  logic [DW-1:0] wq_data[$];

  always #5 clk = ~clk;

  image_dram_writer #(
    .AXI_ADDR_WIDTH (AW),
    .DRAM_DATA_WIDTH(DW),
    .PIXEL_WIDTH    (PW),
    .BEAT_CNT_WIDTH (CW)
  ) dut (
    .m_axi_aclk     (clk),
    .m_axi_areset   (rst),
    .start          (start),
    .frame_base_addr(base),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tready  (s_axis_tready),
    .dram_write_addr(dram_write_addr),
    .dram_write_len (dram_write_len),
    .dram_write_en  (dram_write_en),
    .dram_write_data(dram_write_data),
    .dram_write_busy(dram_write_busy),
    .frame_busy     (frame_busy),
    .frame_done     (frame_done),
    .beat_count     (beat_count)
  );

  // Controller model: busy rises the cycle after a request and lasts 3 cycles.
  assign dram_write_busy = (busy_cnt != 0) || force_busy;
  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (dram_write_en) busy_cnt <= 3;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dram_write_en) begin
      wq_addr.push_back(dram_write_addr);
      wq_data.push_back(dram_write_data);
      chk("en_while_busy", dram_write_busy, 1'b0);
    end
    if (frame_done) done_cnt++;
  end

  function automatic logic [DW-1:0] make_beat(input int unsigned first, input int unsigned n);
    logic [DW-1:0] b;
    b = '0;
    for (int k = 0; k < int'(n); k++) b[k*PW +: PW] = first + k;
    return b;
  endfunction

  task automatic pulse_start(input logic [AW-1:0] a);
    start = 1'b1;
    base  = a;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic push_pixel(input logic [PW-1:0] d, input logic last);
    int unsigned t;
    t = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = last;
    @(negedge clk);
    while (!s_axis_tready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("tready_wait", t < 300, 1'b1);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic [AW-1:0] base_a,
                             input int unsigned first, input int unsigned npix,
                             input int unsigned done_before);
    int unsigned nbeats;
    int unsigned t;
    int unsigned n;
    nbeats = (npix + 15) / 16;
    t = 0;
    while (done_cnt == done_before && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk({tag, "_done"}, done_cnt, done_before + 1);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done_once"}, done_cnt, done_before + 1);
    chk({tag, "_beat_count"}, beat_count, nbeats);
    chk({tag, "_frame_busy"}, frame_busy, 1'b0);
    chk({tag, "_n_writes"}, wq_addr.size(), nbeats);
    for (int b = 0; b < int'(nbeats); b++) begin
      if (wq_addr.size() == 0) break;
      n = (npix - 16*b > 16) ? 16 : npix - 16*b;
      chk({tag, "_addr"}, wq_addr.pop_front(), base_a + AW'(64*b));
      chk({tag, "_data"}, wq_data.pop_front(), make_beat(first + 16*b, n));
    end
    wq_addr.delete();
    wq_data.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d0;
    rst = 1'b1; start = 1'b0; base = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_en", dram_write_en, 1'b0);
    chk("rst_addr", dram_write_addr, '0);
    chk("rst_data", dram_write_data, '0);
    chk("rst_len", dram_write_len, '0);
    chk("rst_busy", frame_busy, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_beat_count", beat_count, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 32 pixels, two full beats
    d0 = done_cnt;
    pulse_start(39'h1000);
    chk("t1_frame_busy", frame_busy, 1'b1);
    for (int i = 0; i < 32; i++) push_pixel(i, i == 31);
    check_frame("t1", 39'h1000, 0, 32, d0);

    // 20 pixels, second beat zero-padded
    d0 = done_cnt;
    pulse_start(39'h1000);
    for (int i = 0; i < 20; i++) push_pixel(i, i == 19);
    check_frame("t2", 39'h1000, 0, 20, d0);

    // controller busy for ~50 cycles while streaming
    d0 = done_cnt;
    force_busy = 1'b1;
    pulse_start(39'h3000);
    for (int i = 0; i < 32; i++) push_pixel(32'h200 + i, 1'b0);
    s_axis_tdata  = 32'h220;
    s_axis_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_tready_full", s_axis_tready, 1'b0);
    chk("t3_no_write", wq_addr.size(), 0);
    s_axis_tvalid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    force_busy = 1'b0;
    for (int i = 32; i < 40; i++) push_pixel(32'h200 + i, i == 39);
    check_frame("t3", 39'h3000, 32'h200, 40, d0);

    // unaligned base and ignored mid-frame start
    d0 = done_cnt;
    pulse_start(39'h1023);
    for (int i = 0; i < 5; i++) push_pixel(32'h300 + i, 1'b0);
    pulse_start(39'h5000);
    for (int i = 5; i < 24; i++) push_pixel(32'h300 + i, i == 23);
    check_frame("t4", 39'h1000, 32'h300, 24, d0);

    // tlast on the 16th pixel
    d0 = done_cnt;
    pulse_start(39'h4000);
    for (int i = 0; i < 16; i++) push_pixel(32'h400 + i, i == 15);
    check_frame("t5", 39'h4000, 32'h400, 16, d0);

    // reset mid-frame, then a clean frame
    pulse_start(39'h6000);
    for (int i = 0; i < 20; i++) push_pixel(32'h600 + i, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mrst_tready", s_axis_tready, 1'b0);
    chk("mrst_en", dram_write_en, 1'b0);
    chk("mrst_addr", dram_write_addr, '0);
    chk("mrst_data", dram_write_data, '0);
    chk("mrst_busy", frame_busy, 1'b0);
    chk("mrst_done", frame_done, 1'b0);
    chk("mrst_beat_count", beat_count, '0);
    rst = 1'b0;
    wq_addr.delete();
    wq_data.delete();
    @(posedge clk); #1;
    d0 = done_cnt;
    pulse_start(39'h2000);
    for (int i = 0; i < 18; i++) push_pixel(32'h700 + i, i == 17);
    check_frame("t6", 39'h2000, 32'h700, 18, d0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/image_dram_writer.md
# image_dram_writer

Upstream feeder for `DRAM_Controller` in the Image2DRAM path. It accepts a pixel stream over AXI4-Stream and packs `WORDS_PER_BEAT` pixels into one `DRAM_DATA_WIDTH` beat. It issues one single-beat write per packed beat on the controller's `dram_write_*` interface, at consecutive 64-byte addresses from a per-frame base. A two-entry buffer (pack plus hold) lets pixel intake overlap with the DRAM write in flight.

## Interface
Parameters:
- `AXI_ADDR_WIDTH`, 39, DRAM byte-address width
- `DRAM_DATA_WIDTH`, 512, beat width
- `PIXEL_WIDTH`, 32, input word width; must divide `DRAM_DATA_WIDTH`
- `WORDS_PER_BEAT`, `DRAM_DATA_WIDTH/PIXEL_WIDTH` (16), lanes per beat
- `BEAT_CNT_WIDTH`, 24, width of the beat counter

Ports:
- `m_axi_aclk`  in  1  single clock for the block
- `m_axi_areset`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse that arms a frame
- `frame_base_addr`  in  `AXI_ADDR_WIDTH`  frame base byte address, sampled on `start`
- `s_axis_tdata`  in  `PIXEL_WIDTH`  pixel word
- `s_axis_tvalid`  in  1  pixel valid
- `s_axis_tlast`  in  1  last pixel of frame
- `s_axis_tready`  out  1  pixel accept
- `dram_write_addr`  out  `AXI_ADDR_WIDTH`  beat address
- `dram_write_len`  out  8  constant 0 (single beat)
- `dram_write_en`  out  1  one-cycle write request
- `dram_write_data`  out  `DRAM_DATA_WIDTH`  beat data
- `dram_write_busy`  in  1  controller busy, registered in the controller
- `frame_busy`  out  1  frame in progress
- `frame_done`  out  1  one-cycle pulse when the last beat's write has completed
- `beat_count`  out  `BEAT_CNT_WIDTH`  beats written in the current or last frame

## Operation
- Reset: every output is 0; both buffers are empty; the FSMs go to their IDLE states.
- Frame FSM states: `F_IDLE`, `F_RUN`, `F_FLUSH`, `F_DONE`.
  - `F_IDLE`: on `start`:
    - latch the address as `frame_base_addr & ~63`;
    - clear `beat_count` and the lane index;
    - go to `F_RUN` with `frame_busy`=1.
  - `start` is ignored in every state other than `F_IDLE`.
  - `F_RUN`: a pixel is accepted when `s_axis_tvalid & s_axis_tready`. Lane k goes to bits `[k*PIXEL_WIDTH +: PIXEL_WIDTH]`, with lane 0 as the first pixel.
  - When `s_axis_tlast` is accepted, go to `F_FLUSH`. If the pack buffer is partly filled, the unfilled lanes are zero and the beat is marked complete. If tlast lands on lane 15, the beat is complete normally; no extra empty beat is generated.
  - `F_FLUSH`: wait until both buffers are empty and the writer is idle, then go to `F_DONE`.
  - `F_DONE`: pulse `frame_done` for one cycle, clear `frame_busy`, return to `F_IDLE`.
- Buffer movement:
  - A complete pack beat moves to hold when hold is empty, or when hold is being released in the same cycle.
  - If hold is occupied, the pack buffer stays full.
- `s_axis_tready` = (state==`F_RUN`) & !(pack full & hold valid).
- Writer FSM states: `W_IDLE`, `W_ISSUE`, `W_ACK`, `W_WAIT`.
  - `W_IDLE`: when hold is valid and `dram_write_busy`=0, drive addr, data and `dram_write_en`=1, and go to `W_ISSUE`.
  - `W_ISSUE`: drop `dram_write_en`, go to `W_ACK`. This covers the controller's one-cycle busy latency.
  - `W_ACK`: go to `W_WAIT`.
  - `W_WAIT`: when `dram_write_busy`=0, release hold, add 64 to the address, increment `beat_count`, go to `W_IDLE`.
- `beat_count` wraps modulo 2^`BEAT_CNT_WIDTH`. The address wraps modulo 2^`AXI_ADDR_WIDTH`.

## Timing
- `dram_write_en` is high for exactly one cycle per beat, and never in a cycle where `dram_write_busy`=1.
- `dram_write_addr` and `dram_write_data` are stable from the `en` cycle until hold is released.
- Latency: if the 16th lane is accepted in cycle N with hold and writer idle, hold is loaded at N+1 and `en` is asserted at N+1 (both registered).
- Minimum spacing between successive `en` pulses is 4 cycles, plus however long the controller keeps busy high.
- `frame_done` fires 1 cycle after `F_FLUSH` sees buffers empty and the writer in `W_IDLE`.
- Reset mid-frame takes effect on the next edge. `dram_write_en` drops at once; any transfer already accepted by the controller is not tracked.

## Structure
- Package `image2dram_pkg`: the frame and writer state enums, and the `BEAT_BYTES` (64) and `WORDS_PER_BEAT` constants.
- One natural sub-module, `pixel_beat_packer`. It owns the lane index, the pack and hold registers and the tready logic. It is a valid/ready source toward the writer FSM.

## Test plan
- `start` with base 0x1000, then 32 pixels 0..31 with tlast on 31:
  - writes at 0x1000 with lanes 0..15 and at 0x1040 with lanes 16..31;
  - `beat_count`=2 and one `frame_done`.
- 20 pixels: the second beat at 0x1040 carries lanes 0..3 = 16..19 and lanes 4..15 = 0. `beat_count`=2.
- Hold `dram_write_busy` high for 50 cycles while streaming:
  - `s_axis_tready` drops after 32 pixels are buffered;
  - no `en` while busy;
  - all data intact in order.
- `start` with base 0x1023: the first write goes to 0x1000. A second `start` mid-frame is ignored.
- tlast exactly on pixel 16: one write only, `beat_count`=1.
- Assert `m_axi_areset` mid-frame:
  - all outputs are 0 the next cycle;
  - a new `start` with base 0x2000 writes correctly from 0x2000.
